// File: rtl/voice_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Package   : synth_mix_pkg
// Purpose   : Shared definitions for the voice mixer: FSM state encoding,
//             accumulator width helper and output saturation limits.
// Revision  : 1.0  initial release
// ============================================================================
package synth_mix_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_scale = 2'd2;
    localparam logic [1:0] c_st_hold  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = c_st_idle,
        S_ACCUM = c_st_accum,
        S_SCALE = c_st_scale,
        S_HOLD  = c_st_hold
    } state_t;

    // Wide signed type used to compare the shifted sum against the output
    // limits independent of the accumulator and output widths.
    localparam int c_wide_w = 128;
    typedef logic signed [c_wide_w-1:0] wide_t;

    // Sum of NUM_UNITS products of C_WIDTH bits needs log2(NUM_UNITS) extra
    // bits to be overflow-free.
    function automatic int acc_width(input int c_width, input int num_units);
        return c_width + $clog2(num_units);
    endfunction

    // Largest positive value representable in out_width signed bits.
    function automatic wide_t sat_max(input int out_width);
        return (wide_t'(1) <<< (out_width - 1)) - wide_t'(1);
    endfunction

    // Most negative value representable in out_width signed bits.
    function automatic wide_t sat_min(input int out_width);
        return -(wide_t'(1) <<< (out_width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/voice_mixer_if.sv
`default_nettype none
// ============================================================================
// Interface : voice_mixer_if
// Purpose   : Bundles the voice mixer's product input, frame control, sample
//             handshake and clip-flag signals.
//             products     - NUM_UNITS packed signed products, voice 0 in LSBs
//             voice_mask   - per-voice enable
//             start        - frame request
//             busy         - mixer not idle
//             sample_out   - saturated signed sample
//             sample_valid - sample_out holds a frame result
//             sample_ready - downstream accepts the sample
//             clip         - sticky saturation flag
//             clip_clear   - clears clip
//             Modport master drives the mixer, modport slave is the mixer.
// Revision  : 1.0  initial release
// ============================================================================
interface voice_mixer_if #(
    parameter int C_WIDTH   = 32,
    parameter int NUM_UNITS = 32,
    parameter int OUT_WIDTH = 16
) ();

    logic [C_WIDTH*NUM_UNITS-1:0] products;
    logic [NUM_UNITS-1:0]         voice_mask;
    logic                         start;
    logic                         busy;
    logic [OUT_WIDTH-1:0]         sample_out;
    logic                         sample_valid;
    logic                         sample_ready;
    logic                         clip;
    logic                         clip_clear;

    modport master (
        output products, voice_mask, start, sample_ready, clip_clear,
        input  busy, sample_out, sample_valid, clip
    );

    modport slave (
        input  products, voice_mask, start, sample_ready, clip_clear,
        output busy, sample_out, sample_valid, clip
    );

endinterface
`default_nettype wire

// File: rtl/voice_mixer_sat_shift.sv
`default_nettype none
// ============================================================================
// Module    : sat_shift
// Purpose   : Combinational arithmetic right shift of the accumulator followed
//             by saturation to a signed OUT_WIDTH result.
//             i_acc       - signed accumulator
//             o_result    - shifted, saturated sample
//             o_saturated - high when o_result was clamped
// Revision  : 1.0  initial release
// ============================================================================
module sat_shift
    import synth_mix_pkg::*;
#(
    parameter int ACC_W     = 37,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SHIFT = 8
) (
    input  wire logic signed [ACC_W-1:0] i_acc,
    output logic [OUT_WIDTH-1:0]         o_result,
    output logic                         o_saturated
);

    localparam wide_t c_max = sat_max(OUT_WIDTH);
    localparam wide_t c_min = sat_min(OUT_WIDTH);

    logic signed [ACC_W-1:0] w_shifted;
    wide_t                   w_wide;

    assign w_shifted = i_acc >>> OUT_SHIFT;
    // Sign-extend so the limit comparison is width-independent.
    assign w_wide    = {{(c_wide_w-ACC_W){w_shifted[ACC_W-1]}}, w_shifted};

    always_comb begin
        o_result    = w_wide[OUT_WIDTH-1:0];
        o_saturated = 1'b0;
        if (w_wide > c_max) begin
            o_result    = c_max[OUT_WIDTH-1:0];
            o_saturated = 1'b1;
        end else if (w_wide < c_min) begin
            o_result    = c_min[OUT_WIDTH-1:0];
            o_saturated = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/voice_mixer.sv
`default_nettype none
// ============================================================================
// Module    : voice_mixer
// Purpose   : Sums the per-voice products of the TDM multiplier into one
//             signed audio sample per frame. A start in IDLE snapshots the
//             product bus and voice mask, enabled voices are accumulated one
//             per cycle, the sum is shifted and saturated, and the sample is
//             held under a valid/ready handshake.
//             ctl_clk - clock
//             ctl_rst - synchronous active-high reset
//             bus     - voice_mixer_if.slave (products, mask, start, busy,
//                       sample handshake, clip flag)
//             Build option: define MIXER_CLIP_FLAG_EN to build the sticky
//             clip flag; otherwise clip is tied low and clip_clear ignored.
// Revision  : 1.0  initial release
// ============================================================================
module voice_mixer
    import synth_mix_pkg::*;
#(
    parameter int C_WIDTH   = 32,
    parameter int NUM_UNITS = 32,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SHIFT = 8
) (
    input  wire logic  ctl_clk,
    input  wire logic  ctl_rst,
    voice_mixer_if.slave bus
);

    localparam int ACC_W = acc_width(C_WIDTH, NUM_UNITS);
    localparam int IDX_W = $clog2(NUM_UNITS);
    localparam int EXT_W = ACC_W - C_WIDTH;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_UNITS - 1);

    state_t                            r_state;
    state_t                            w_state_next;
    logic [NUM_UNITS-1:0][C_WIDTH-1:0] r_snap;
    logic [NUM_UNITS-1:0]              r_mask;
    logic signed [ACC_W-1:0]           r_acc;
    logic [IDX_W-1:0]                  r_idx;
    logic [OUT_WIDTH-1:0]              r_sample;
    logic                              r_valid;
    logic                              r_busy;
    logic signed [ACC_W-1:0]           w_addend;
    logic [OUT_WIDTH-1:0]              w_sat_result;
    logic                              w_saturated;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ctl_clk) begin
        if (ctl_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)          w_state_next = S_ACCUM;
            S_ACCUM: if (r_idx == c_last_idx) w_state_next = S_SCALE;
            S_SCALE:                          w_state_next = S_HOLD;
            S_HOLD:  if (bus.sample_ready)   w_state_next = S_IDLE;
            default:                          w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_addend = r_mask[r_idx]
                    ? {{EXT_W{r_snap[r_idx][C_WIDTH-1]}}, r_snap[r_idx]}
                    : '0;

    sat_shift #(
        .ACC_W     (ACC_W),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_sat_shift (
        .i_acc       (r_acc),
        .o_result    (w_sat_result),
        .o_saturated (w_saturated)
    );

    always_ff @(posedge ctl_clk) begin
        if (ctl_rst) begin
            r_snap   <= '0;
            r_mask   <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            // Registered so busy has no decode logic after the flop.
            r_busy <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_snap <= bus.products;
                        r_mask <= bus.voice_mask;
                        r_acc  <= '0;
                        r_idx  <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + w_addend;
                    // Power-of-two NUM_UNITS: wraps to 0 after the last voice.
                    r_idx <= r_idx + 1'b1;
                end
                S_SCALE: begin
                    r_sample <= w_sat_result;
                    r_valid  <= 1'b1;
                end
                S_HOLD: begin
                    if (bus.sample_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky clip flag
    // ------------------------------------------------------------------
`ifdef MIXER_CLIP_FLAG_EN
    logic r_clip;

    always_ff @(posedge ctl_clk) begin
        if (ctl_rst) begin
            r_clip <= 1'b0;
        end else if ((r_state == S_SCALE) && w_saturated) begin
            // A set takes priority over a simultaneous clear.
            r_clip <= 1'b1;
        end else if (bus.clip_clear) begin
            r_clip <= 1'b0;
        end
    end

    assign bus.clip = r_clip;
`else
    logic w_unused_clip;

    assign w_unused_clip = bus.clip_clear ^ w_saturated;
    assign bus.clip      = 1'b0;
`endif

    assign bus.sample_out   = r_sample;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: doc/voice_mixer.md
# voice_mixer

- Sums the per-voice products of the time-division-multiplexed multiplier into one signed audio sample per frame.
- Each frame: snapshot the product bus, accumulate enabled voices one per cycle, shift and saturate to the output width, then hold the sample under a valid/ready handshake.
- Position: directly downstream of the TDM multiplier, feeding the audio output stage.

## Interface

Parameters:
- C_WIDTH, 32: width of each signed product.
- NUM_UNITS, 32: number of voices; a power of two, 2..64.
- OUT_WIDTH, 16: output sample width (signed).
- OUT_SHIFT, 8: arithmetic right shift applied to the sum before saturation.

Ports:
- ctl_clk  in  1  sole clock.
- ctl_rst  in  1  synchronous, active-high reset.
- products  in  C_WIDTH*NUM_UNITS  voice i occupies bits [C_WIDTH*(i+1)-1 : C_WIDTH*i], two's complement.
- voice_mask  in  NUM_UNITS  bit i = 1 includes voice i.
- start  in  1  frame request; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- sample_out  out  OUT_WIDTH  saturated signed sample.
- sample_valid  out  1  sample_out holds a frame result.
- sample_ready  in  1  downstream accepts the sample.
- clip  out  1  sticky saturation flag.
- clip_clear  in  1  clears clip.

## Operation

- States: IDLE, ACCUM, SCALE, HOLD.
- **IDLE**
  - On start: snap <= products, mask_r <= voice_mask, acc <= 0, idx <= 0, go to ACCUM.
- **ACCUM**
  - Each cycle: acc <= acc + (mask_r[idx] ? sext(snap[idx]) : 0), idx <= idx + 1.
  - After the add with idx == NUM_UNITS-1: go to SCALE. idx wraps to 0.
- **SCALE**
  - s = acc >>> OUT_SHIFT.
  - If s > 2^(OUT_WIDTH-1)-1, output the max; if s < -2^(OUT_WIDTH-1), output the min; otherwise output s truncated to OUT_WIDTH.
  - Registers sample_out, sets sample_valid = 1, goes to HOLD.
- **HOLD**
  - sample_out and sample_valid stay stable until sample_ready is sampled high.
  - At that edge: sample_valid <= 0, go to IDLE. sample_out keeps its last value.
- **Arithmetic**
  - acc is signed, C_WIDTH + log2(NUM_UNITS) bits. It cannot overflow.
- **start handling**
  - start is ignored in ACCUM, SCALE and HOLD; it is not queued.
  - A new frame needs start in IDLE, i.e. at least one cycle after the handshake.
- **products stability**
  - products may change at any time after the start edge, because the snapshot isolates the frame.
- **clip**
  - Set in SCALE when saturation occurs; cleared by clip_clear.
  - A set and a clear in the same cycle: set wins.
- **Reset**
  - Synchronous, at any state including mid-ACCUM: next state is IDLE.
  - sample_out = 0, sample_valid = 0, busy = 0, clip = 0; acc, idx, snap, mask_r all 0.
  - A frame interrupted by reset produces no output.

## Timing

- Start sampled at edge E0. ACCUM occupies edges E1..E_NUM_UNITS. SCALE is edge E_(NUM_UNITS+1).
- sample_valid is high from E_(NUM_UNITS+1), i.e. NUM_UNITS+1 cycles after E0.
- busy rises after E0 and falls after the handshake edge.
- sample_ready already high when valid rises: transfer at the next edge, so valid lasts exactly 1 cycle.
- Minimum frame period: NUM_UNITS+3 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration

- MIXER_CLIP_FLAG_EN defined: clip behaves as described; clip_clear is used.
- MIXER_CLIP_FLAG_EN undefined:
  - The clip register is not built and clip is tied to 0.
  - clip_clear is ignored.
  - Saturation of sample_out still happens.

## Structure

- Package synth_mix_pkg holds:
  - state encoding constants (IDLE=2'd0, ACCUM=2'd1, SCALE=2'd2, HOLD=2'd3);
  - the accumulator-width expression;
  - the OUT_WIDTH saturation limits.
- Sub-module sat_shift: combinational arithmetic shift plus saturation.
  - Input: accumulator. Outputs: OUT_WIDTH result and a saturated flag.
  - Instantiated once, used in SCALE.
- The FSM, snapshot, index counter and handshake live in voice_mixer.

## Test plan

All scenarios use NUM_UNITS=4, C_WIDTH=32, OUT_WIDTH=16, OUT_SHIFT=8.

- Basic sum: products {0x100,0x200,0x300,0x400}, mask 4'b1111, start, ready=1 -> sample_out=0x000A; valid rises 5 cycles after the start edge, high for 1 cycle; clip=0.
- Negative: all products 0xFFFFFF00, mask 4'b1111 -> sample_out=0xFFFC.
- Masking: basic-sum products, mask 4'b0101 -> sample_out=0x0004.
- Saturation: all products 0x01000000 -> sample_out=0x7FFF and clip=1; all 0xFF000000 -> 0x8000. clip_clear then drops clip. With the macro undefined, clip stays 0.
- Backpressure: ready=0 for 10 cycles after valid, start pulsed, products changed -> sample_out and valid stable, start ignored. Ready=1 -> valid low and busy low next cycle.
- Reset mid-frame: ctl_rst at the second ACCUM cycle -> next cycle all outputs 0 and state IDLE, no valid. A following start yields a correct fresh sum.
